// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: FSM encoding and register map shared by the peripheral bus master.
package periph_bus_pkg;
  typedef enum logic [2:0] {
    IDLE, BUS, RSP, ISR_RD_TCON, ISR_WR_TCON, ISR_RD_SW, ISR_WR_LED
  } state_e;
  localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;
  localparam logic [31:0] TH_OFS = 32'h00;
  localparam logic [31:0] TL_OFS = 32'h04;
  localparam logic [31:0] TCON_OFS = 32'h08;
  localparam logic [31:0] LED_OFS = 32'h0C;
  localparam logic [31:0] SW_OFS = 32'h10;
  localparam logic [31:0] DIGI_OFS = 32'h14;
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IRQ = 2;
endpackage

// File: rtl/periph_bus_master.sv
// periph_bus_master: command-driven initiator for the single-cycle peripheral bus,
// with a built-in timer interrupt service (ack TCON, copy switches to LEDs).
module periph_bus_master
  import periph_bus_pkg::*;
#(
  parameter bit ISR_EN = 1'b1,
  parameter logic [31:0] TCON_ADDR = PERIPH_BASE + TCON_OFS,
  parameter logic [31:0] LED_ADDR = PERIPH_BASE + LED_OFS,
  parameter logic [31:0] SW_ADDR = PERIPH_BASE + SW_OFS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_wr,
  output logic [31:0] Addr,
  output logic [31:0] WriteData,
  output logic        MemRd,
  output logic        MemWr,
  input  logic [31:0] ReadData,
  input  logic        irqin,
  output logic        isr_busy,
  output logic [15:0] isr_count
);
  localparam logic [2:0] TCON_KEEP = (3'b1 << TCON_EN) | (3'b1 << TCON_IE);
  state_e state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic rd_q, rd_d, wr_q, wr_d, rsp_valid_q, rsp_valid_d, rsp_wr_q, rsp_wr_d;
  logic isr_busy_q, isr_busy_d;
  logic [15:0] isr_count_q, isr_count_d;
  logic take_isr;
  assign take_isr = ISR_EN && irqin;
  assign cmd_ready = (state_q == IDLE) && !take_isr;
  // Bus outputs for a state are registered on entry, so each state is exactly one bus cycle.
  always_comb begin
    state_d = state_q;
    addr_d = '0;
    wdata_d = '0;
    rd_d = 1'b0;
    wr_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_wr_d = rsp_wr_q;
    isr_busy_d = 1'b0;
    isr_count_d = isr_count_q;
    case (state_q)
      IDLE: begin
        if (take_isr) begin
          state_d = ISR_RD_TCON;
          addr_d = TCON_ADDR;
          rd_d = 1'b1;
          isr_busy_d = 1'b1;
        end else if (cmd_valid) begin
          state_d = BUS;
          addr_d = cmd_addr;
          wdata_d = cmd_wdata;
          wr_d = cmd_wr;
          rd_d = !cmd_wr;
        end
      end
      BUS: begin
        state_d = RSP;
        rsp_valid_d = 1'b1;
        rsp_wr_d = wr_q;
        rsp_rdata_d = rd_q ? ReadData : '0;
      end
      RSP: begin
        state_d = rsp_ready ? IDLE : RSP;
        rsp_valid_d = !rsp_ready;
      end
      ISR_RD_TCON: begin
        state_d = ISR_WR_TCON;
        addr_d = TCON_ADDR;
        wdata_d = {29'b0, ReadData[2:0] & TCON_KEEP};
        wr_d = 1'b1;
        isr_busy_d = 1'b1;
      end
      ISR_WR_TCON: begin
        state_d = ISR_RD_SW;
        addr_d = SW_ADDR;
        rd_d = 1'b1;
        isr_busy_d = 1'b1;
      end
      ISR_RD_SW: begin
        state_d = ISR_WR_LED;
        addr_d = LED_ADDR;
        wdata_d = {24'b0, ReadData[7:0]};
        wr_d = 1'b1;
        isr_busy_d = 1'b1;
      end
      ISR_WR_LED: begin
        state_d = IDLE;
        isr_count_d = isr_count_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_wr_q <= 1'b0;
      isr_busy_q <= 1'b0;
      isr_count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_wr_q <= rsp_wr_d;
      isr_busy_q <= isr_busy_d;
      isr_count_q <= isr_count_d;
    end
  end
  assign Addr = addr_q;
  assign WriteData = wdata_q;
  assign MemRd = rd_q;
  assign MemWr = wr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_wr = rsp_wr_q;
  assign isr_busy = isr_busy_q;
  assign isr_count = isr_count_q;
endmodule

// File: doc/periph_bus_master.md
# periph_bus_master

Bus initiator for the memory-mapped peripheral space at 0x4000_0000. It accepts read/write commands over a valid/ready handshake and drives the single-cycle peripheral bus (`Addr`, `WriteData`, `MemRd`, `MemWr`, `ReadData`). It returns each result over a response handshake. When the peripheral's timer interrupt is raised, it also runs a fixed hardware service sequence: clear the interrupt, then copy the switches to the LEDs. It sits between the debug/command source and the peripheral block, as the other end of that bus.

## Interface
- `ISR_EN`, 1: enables the hardware interrupt service sequence; 0 ignores `irqin`.
- `TCON_ADDR`, 32'h4000_0008: timer control register address.
- `LED_ADDR`, 32'h4000_000C: LED register address.
- `SW_ADDR`, 32'h4000_0010: switch register address.

Ports:
- `clk` in 1: single clock; all state on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid` and `cmd_ready` are both high at an edge.
- `cmd_wr` in 1: 1 = write, 0 = read.
- `cmd_addr` in 32: bus address.
- `cmd_wdata` in 32: write data.
- `rsp_valid` out 1: response held until accepted.
- `rsp_ready` in 1: response consumer ready.
- `rsp_rdata` out 32: read data; 0 for writes.
- `rsp_wr` out 1: echo of `cmd_wr`.
- `Addr` out 32: bus address, registered.
- `WriteData` out 32: bus write data, registered.
- `MemRd` out 1: bus read strobe, registered.
- `MemWr` out 1: bus write strobe, registered.
- `ReadData` in 32: responder read data, combinational from `Addr`/`MemRd`.
- `irqin` in 1: level interrupt, equal to TCON[2].
- `isr_busy` out 1: high while the service sequence runs.
- `isr_count` out 16: number of completed services.

## Operation
- FSM states: IDLE, BUS, RSP, ISR_RD_TCON, ISR_WR_TCON, ISR_RD_SW, ISR_WR_LED.
- Reset values: all outputs 0, state IDLE, internal latches 0.
- IDLE, `cmd_ready`:
  - `cmd_ready` = 1 only in IDLE, and only when not taking the ISR this cycle.
  - Priority: if `ISR_EN` and `irqin` are high in IDLE, go to ISR_RD_TCON. `cmd_ready` = 0 that cycle, so a pending command waits.
- Accepted command:
  - Latch `cmd_addr`, `cmd_wdata` and `cmd_wr`.
  - Go to BUS, driving `Addr`/`WriteData` and exactly one of `MemRd`/`MemWr` for one cycle.
- BUS:
  - At the end of BUS, capture `ReadData` into `rsp_rdata` on a read, or 0 on a write.
  - Strobes drop and the next state is RSP.
- RSP: hold `rsp_valid` = 1 and `rsp_rdata`/`rsp_wr` stable until `rsp_ready`, then go to IDLE.
- Bus idle value: whenever no strobe is asserted, `Addr` = 0 and `WriteData` = 0. A strobe is never asserted for more than one cycle per access.
- ISR sequence (each state is one bus cycle):
  - ISR_RD_TCON: read `TCON_ADDR` and latch t = ReadData[2:0].
  - ISR_WR_TCON: write {29'b0, t & 3'b011}, which clears the interrupt and keeps the enable bits.
  - ISR_RD_SW: read `SW_ADDR` and latch s = ReadData[7:0].
  - ISR_WR_LED: write {24'b0, s} to `LED_ADDR`. Then increment `isr_count` (16-bit, wraps 0xFFFF→0) and go to IDLE.
- `isr_busy` = 1 in all four ISR states.
- `irqin` is sampled only in IDLE. An interrupt arriving during a command or ISR is serviced on the next IDLE cycle.
- The responder's write has priority over a simultaneous timer-set of TCON[2]. An overflow coinciding with ISR_WR_TCON is therefore lost; this is accepted behaviour.
- Reset mid-operation: strobes drop asynchronously, the in-flight command or response is discarded, `isr_count` returns to 0, and the state returns to IDLE.

## Timing
- Command accepted at edge k: strobe high during cycle k+1; `rsp_valid` high from k+2.
- Minimum command period: 3 cycles with `rsp_ready` tied high.
- ISR: 4 bus cycles plus 1 IDLE decision cycle. `irqin` falls after the ISR_WR_TCON edge.
- `cmd_ready` depends only on state and `irqin`, never on `cmd_valid`. There is no combinational path from `rsp_ready` to any bus output.

## Structure
- Shared package `periph_bus_pkg` holds:
  - the FSM state enum;
  - the peripheral address constants (TH 0x00, TL 0x04, TCON 0x08, LED 0x0C, SW 0x10, DIGI 0x14, offsets from 0x4000_0000);
  - the TCON bit indices (EN 0, IE 1, IRQ 2).
- Single module; no sub-module is warranted.

## Test plan
- Write: command (wr, 0x4000_000C, 0x5A) → `MemWr`=1 for exactly one cycle with `Addr`=0x4000_000C and `WriteData`=0x5A; `rsp_valid` with `rsp_rdata`=0 two cycles after accept.
- Read with backpressure: read of 0x4000_0010 with model switch=0xA5 and `rsp_ready` held low for 5 cycles → `rsp_rdata`=0xA5 held stable; `cmd_ready`=0 until the response is accepted.
- ISR: model TCON=3'b111 with `irqin` high → bus sequence RD 0x08, WR 0x08=0x3, RD 0x10, WR 0x0C=switch; `isr_count` 0→1; `irqin` low afterwards.
- ISR priority: `irqin` and `cmd_valid` rise together in IDLE → ISR runs first and the command is accepted in the IDLE cycle after it; `ISR_EN`=0 → `irqin` is ignored.
- Reset mid-BUS: assert `reset` low during a read strobe → `MemRd` drops immediately, no `rsp_valid` appears after release, and `isr_count`=0.
- Counter wrap: preload or run 65536 services → `isr_count` wraps to 0.
